// File: rtl/jtopl_acc_pkg.sv
// Shared constants and encodings for the jtopl output path.
package jtopl_acc_pkg;

    localparam int SLOTS    = 18;
    localparam int CHANNELS = 9;
    localparam int OP_W     = 14;
    localparam int OUT_W    = 16;

    // Channel connection: FM routes the modulator into the carrier only,
    // additive makes both operators audible.
    typedef enum logic {
        CON_FM  = 1'b0,
        CON_ADD = 1'b1
    } con_e;

endpackage

// File: rtl/jtopl_acc_if.sv
// Operator-stage to accumulator link plus the resulting sound output.
interface jtopl_acc_if #(
    parameter int OPW = 14
);
    logic                  cenop;
    logic                  zero;
    logic                  op;
    logic                  con;
    logic signed [OPW-1:0] op_result;
    logic signed [15:0]    sound;
    logic                  sample;

    // Operator stage side: drives slots, observes the mixed output.
    modport master (
        output cenop, zero, op, con, op_result,
        input  sound, sample
    );

    // Accumulator side.
    modport slave (
        input  cenop, zero, op, con, op_result,
        output sound, sample
    );
endinterface

// File: rtl/jtopl_acc_sat.sv
// Signed saturator: clamps an IN_W value into OUT_W bits.
module jtopl_sat #(
    parameter int IN_W  = 19,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    generate
        if (IN_W > OUT_W) begin : g_clamp
            // The value fits when every bit above the output sign bit
            // matches it; otherwise clamp toward the input's sign.
            function automatic logic signed [OUT_W-1:0] sat(input logic signed [IN_W-1:0] x);
                logic [IN_W-OUT_W:0] top;
                top = x[IN_W-1:OUT_W-1];
                if (top == '0 || top == '1)
                    return x[OUT_W-1:0];
                else if (x[IN_W-1])
                    return {1'b1, {(OUT_W-1){1'b0}}};
                else
                    return {1'b0, {(OUT_W-1){1'b1}}};
            endfunction

            // Pure combinational clamp.
            always_comb dout = sat(din);
        end else begin : g_extend
            // Output wide enough: plain sign extension.
            always_comb dout = OUT_W'(din);
        end
    endgenerate

endmodule

// File: rtl/jtopl_acc.sv
// Frame accumulator: sums audible operator slots over one frame,
// applies a fixed gain and presents a saturated 16-bit sample.
module jtopl_acc
    import jtopl_acc_pkg::*;
#(
    parameter int OPW  = 14,
    parameter int ACCW = 19,
    parameter int GAIN = 0
) (
    input logic         clk,
    input logic         rst,
    jtopl_acc_if.slave  bus
);

    logic signed [ACCW-1:0]      contrib;
    logic signed [ACCW+GAIN-1:0] shifted;
    logic signed [OUT_W-1:0]     sat_val;

    logic signed [ACCW-1:0]  acc_d,    acc_q;
    logic signed [OUT_W-1:0] sound_d,  sound_q;
    logic                    sample_d, sample_q;

    // Only carriers, or both operators of an additive channel, are audible.
    always_comb begin
        contrib = '0;
        if (bus.op || bus.con == CON_ADD)
            contrib = {{(ACCW-OPW){bus.op_result[OPW-1]}}, bus.op_result};
    end

    // Gain is applied at the widened width so the saturator sees the true value.
    always_comb shifted = (ACCW+GAIN)'(acc_q) <<< GAIN;

    jtopl_sat #(
        .IN_W  (ACCW+GAIN),
        .OUT_W (OUT_W)
    ) u_sat (
        .din  (shifted),
        .dout (sat_val)
    );

    // Frame sequencing: zero closes the running frame and seeds the next one.
    always_comb begin
        acc_d    = acc_q;
        sound_d  = sound_q;
        sample_d = 1'b0;
        if (bus.cenop) begin
            if (bus.zero) begin
                sound_d  = sat_val;
                acc_d    = contrib;
                sample_d = 1'b1;
            end else begin
                acc_d = acc_q + contrib;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            sound_q  <= '0;
            sample_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sound_q  <= sound_d;
            sample_q <= sample_d;
        end
    end

    assign bus.sound  = sound_q;
    assign bus.sample = sample_q;

endmodule
